// File: rtl/bitonic_network_8.sv
// bitonic_network_8: 3-stage pipelined bitonic merge of two ascending 4-record tuples
module bitonic_network_8 #(
  parameter int DATA_WIDTH = 128,
  parameter int KEY_WIDTH  = 80
) (
  input  logic                    i_clk,
  input  logic                    i_rst_n,
  input  logic                    switch_output,
  input  logic                    stall,
  input  logic [4*DATA_WIDTH-1:0] top_tuple,
  input  logic [4*DATA_WIDTH-1:0] i_elems_0,
  input  logic [4*DATA_WIDTH-1:0] i_elems_1,
  output logic [4*DATA_WIDTH-1:0] o_elems_0,
  output logic [4*DATA_WIDTH-1:0] o_elems_1,
  output logic                    o_switch_output,
  output logic                    o_stall,
  output logic [4*DATA_WIDTH-1:0] o_top_tuple
);
  logic [DATA_WIDTH-1:0] x0 [8];
  logic [DATA_WIDTH-1:0] n1 [8];
  logic [DATA_WIDTH-1:0] r1 [8];
  logic [DATA_WIDTH-1:0] n2 [8];
  logic [DATA_WIDTH-1:0] r2 [8];
  logic [DATA_WIDTH-1:0] n3 [8];
  logic [DATA_WIDTH-1:0] r3 [8];
  logic [2:0] sw_q, st_q;
  logic [4*DATA_WIDTH-1:0] top_q [3];
  // k indexes the four compare-exchange units of each stage; swaps only on strictly greater keys
  for (genvar k = 0; k < 4; k++) begin : g_net
    localparam int L2 = (k / 2) * 4 + k % 2;
    logic s1, s2, s3;
    assign x0[k]     = i_elems_0[k*DATA_WIDTH +: DATA_WIDTH];
    assign x0[k+4]   = i_elems_1[k*DATA_WIDTH +: DATA_WIDTH];
    assign s1        = x0[k][KEY_WIDTH-1:0] > x0[7-k][KEY_WIDTH-1:0];
    assign n1[k]     = s1 ? x0[7-k] : x0[k];
    assign n1[7-k]   = s1 ? x0[k] : x0[7-k];
    assign s2        = r1[L2][KEY_WIDTH-1:0] > r1[L2+2][KEY_WIDTH-1:0];
    assign n2[L2]    = s2 ? r1[L2+2] : r1[L2];
    assign n2[L2+2]  = s2 ? r1[L2] : r1[L2+2];
    assign s3        = r2[2*k][KEY_WIDTH-1:0] > r2[2*k+1][KEY_WIDTH-1:0];
    assign n3[2*k]   = s3 ? r2[2*k+1] : r2[2*k];
    assign n3[2*k+1] = s3 ? r2[2*k] : r2[2*k+1];
    assign o_elems_0[k*DATA_WIDTH +: DATA_WIDTH] = r3[k];
    assign o_elems_1[k*DATA_WIDTH +: DATA_WIDTH] = r3[k+4];
  end
  always_ff @(posedge i_clk or negedge i_rst_n)
    if (!i_rst_n) begin
      for (int i = 0; i < 8; i++) begin
        r1[i] <= '0;
        r2[i] <= '0;
        r3[i] <= '0;
      end
      for (int i = 0; i < 3; i++) top_q[i] <= '0;
      sw_q <= '0;
      st_q <= '1;
    end else begin
      r1 <= n1;
      r2 <= n2;
      r3 <= n3;
      top_q[0] <= top_tuple;
      top_q[1] <= top_q[0];
      top_q[2] <= top_q[1];
      sw_q <= {sw_q[1:0], switch_output};
      st_q <= {st_q[1:0], stall};
    end
  assign o_top_tuple     = top_q[2];
  assign o_switch_output = sw_q[2];
  assign o_stall         = st_q[2];
endmodule

// File: tb/tb_bitonic_network_8.sv
// tb_bitonic_network_8: table, random-stream, reset and chaining checks against a sorting model
module tb_bitonic_network_8;
  localparam int DW = 16, KW = 8;
  typedef logic [4*DW-1:0] tup_t;
  typedef struct { tup_t a, b, e0, e1; } vec_t;
  typedef struct { tup_t e0, e1, top; logic sw, st; } exp_t;
  logic i_clk = 0, i_rst_n = 0, switch_output = 0, stall = 1;
  tup_t top_tuple = '0, i_elems_0 = '0, i_elems_1 = '0;
  tup_t o_elems_0, o_elems_1, o_top_tuple, c_elems_0, c_elems_1, c_top;
  logic o_switch_output, o_stall, c_sw, c_st;
  int pass = 0, total = 0;
  exp_t q[$];
  vec_t tv[6];
  always #5 i_clk = ~i_clk;
  bitonic_network_8 #(.DATA_WIDTH(DW), .KEY_WIDTH(KW)) dut (
    .i_clk(i_clk), .i_rst_n(i_rst_n), .switch_output(switch_output), .stall(stall),
    .top_tuple(top_tuple), .i_elems_0(i_elems_0), .i_elems_1(i_elems_1),
    .o_elems_0(o_elems_0), .o_elems_1(o_elems_1), .o_switch_output(o_switch_output),
    .o_stall(o_stall), .o_top_tuple(o_top_tuple));
  bitonic_network_8 #(.DATA_WIDTH(DW), .KEY_WIDTH(KW)) u2 (
    .i_clk(i_clk), .i_rst_n(i_rst_n), .switch_output(o_switch_output), .stall(o_stall),
    .top_tuple(o_top_tuple), .i_elems_0(o_top_tuple), .i_elems_1(o_elems_1),
    .o_elems_0(c_elems_0), .o_elems_1(c_elems_1), .o_switch_output(c_sw),
    .o_stall(c_st), .o_top_tuple(c_top));
  function automatic tup_t pk(input logic [15:0] r0, r1, r2, r3);
    return {r3, r2, r1, r0};
  endfunction
  // golden model: stable insertion sort of all 8 records by key; low half = o0, high half = o1
  function automatic logic [8*DW-1:0] gsort(input tup_t a, input tup_t b);
    logic [DW-1:0] r[8];
    logic [DW-1:0] t;
    logic [8*DW-1:0] res;
    for (int i = 0; i < 4; i++) begin
      r[i] = a[i*DW +: DW];
      r[i+4] = b[i*DW +: DW];
    end
    for (int i = 1; i < 8; i++)
      for (int j = i; j > 0 && r[j-1][KW-1:0] > r[j][KW-1:0]; j--) begin
        t = r[j]; r[j] = r[j-1]; r[j-1] = t;
      end
    for (int i = 0; i < 8; i++) res[i*DW +: DW] = r[i];
    return res;
  endfunction
  function automatic tup_t sort4(input tup_t a);
    logic [DW-1:0] r[4];
    logic [DW-1:0] t;
    for (int i = 0; i < 4; i++) r[i] = a[i*DW +: DW];
    for (int i = 0; i < 3; i++)
      for (int j = 0; j < 3 - i; j++)
        if (r[j][KW-1:0] > r[j+1][KW-1:0]) begin
          t = r[j]; r[j] = r[j+1]; r[j+1] = t;
        end
    return {r[3], r[2], r[1], r[0]};
  endfunction
  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act === exp) pass++;
    else $display("FAIL %s: got %h expected %h", nm, act, exp);
  endtask
  task automatic step(input tup_t a, input tup_t b, input tup_t top, input logic sw,
                      input logic st, input tup_t e0, input tup_t e1);
    exp_t e;
    i_elems_0 = a; i_elems_1 = b; top_tuple = top; switch_output = sw; stall = st;
    q.push_back('{e0, e1, top, sw, st});
    @(posedge i_clk); #1;
    if (q.size() == 3) begin
      e = q.pop_front();
      chk("o_elems_0", o_elems_0, e.e0);
      chk("o_elems_1", o_elems_1, e.e1);
      chk("o_top_tuple", o_top_tuple, e.top);
      chk("o_switch_output", 64'(o_switch_output), 64'(e.sw));
      chk("o_stall", 64'(o_stall), 64'(e.st));
    end
  endtask
  initial begin
    logic [7:0] k[8];
    logic [7:0] tg[8];
    bit dup;
    tup_t a, b, top;
    logic [8*DW-1:0] g, g2;
    #12;
    chk("reset_o0", o_elems_0, '0);
    chk("reset_o1", o_elems_1, '0);
    chk("reset_top", o_top_tuple, '0);
    chk("reset_sw", 64'(o_switch_output), 64'd0);
    chk("reset_stall", 64'(o_stall), 64'd1);
    i_rst_n = 1;
    tv[0] = '{pk(1, 3, 5, 7), pk(2, 4, 6, 8), pk(1, 2, 3, 4), pk(5, 6, 7, 8)};
    tv[1] = '{pk(9, 10, 11, 12), pk(1, 2, 3, 4), pk(1, 2, 3, 4), pk(9, 10, 11, 12)};
    tv[2] = '{pk(1, 2, 3, 4), pk(9, 10, 11, 12), pk(1, 2, 3, 4), pk(9, 10, 11, 12)};
    tv[3] = '{pk(16'h0A05, 16'h0A05, 16'h0A05, 16'h0A05), pk(16'h0B05, 16'h0B05, 16'h0B05, 16'h0B05),
              pk(16'h0A05, 16'h0A05, 16'h0A05, 16'h0A05), pk(16'h0B05, 16'h0B05, 16'h0B05, 16'h0B05)};
    tv[4] = '{pk(16'hFF01, 16'hEE03, 16'hDD05, 16'hCC07), pk(16'h0102, 16'h0204, 16'h0306, 16'h0408),
              pk(16'hFF01, 16'h0102, 16'hEE03, 16'h0204), pk(16'hDD05, 16'h0306, 16'hCC07, 16'h0408)};
    tv[5] = '{pk(16'h1000, 16'h1101, 16'h12FE, 16'h13FF), pk(16'h2002, 16'h2180, 16'h2281, 16'h23FD),
              pk(16'h1000, 16'h1101, 16'h2002, 16'h2180), pk(16'h2281, 16'h23FD, 16'h12FE, 16'h13FF)};
    for (int i = 0; i < 6; i++)
      step(tv[i].a, tv[i].b, tv[i].b, 1'(i), 1'b0, tv[i].e0, tv[i].e1);
    for (int n = 0; n < 1000; n++) begin
      for (int i = 0; i < 8; i++) begin
        do begin
          k[i] = 8'($urandom);
          dup = 0;
          for (int j = 0; j < i; j++) if (k[j] == k[i]) dup = 1;
        end while (dup);
        tg[i] = 8'($urandom);
      end
      a = sort4(pk({tg[0], k[0]}, {tg[1], k[1]}, {tg[2], k[2]}, {tg[3], k[3]}));
      b = sort4(pk({tg[4], k[4]}, {tg[5], k[5]}, {tg[6], k[6]}, {tg[7], k[7]}));
      top = {$urandom, $urandom};
      g = gsort(a, b);
      step(a, b, top, 1'($urandom), 1'($urandom), g[63:0], g[127:64]);
    end
    #3 i_rst_n = 0;
    #1;
    chk("midrst_o0", o_elems_0, '0);
    chk("midrst_o1", o_elems_1, '0);
    chk("midrst_top", o_top_tuple, '0);
    chk("midrst_sw", 64'(o_switch_output), 64'd0);
    chk("midrst_stall", 64'(o_stall), 64'd1);
    q.delete();
    @(posedge i_clk); #1;
    chk("rst_held_stall", 64'(o_stall), 64'd1);
    i_elems_0 = pk(1, 3, 5, 7); i_elems_1 = pk(2, 4, 6, 8); top_tuple = pk(1, 3, 5, 7);
    switch_output = 1; stall = 0;
    i_rst_n = 1;
    for (int c = 1; c <= 3; c++) begin
      @(posedge i_clk); #1;
      chk("rst_rel_stall", 64'(o_stall), (c < 3) ? 64'd1 : 64'd0);
    end
    chk("rst_rel_o0", o_elems_0, pk(1, 2, 3, 4));
    chk("rst_rel_o1", o_elems_1, pk(5, 6, 7, 8));
    chk("rst_rel_sw", 64'(o_switch_output), 64'd1);
    a = pk(1, 4, 6, 7); b = pk(2, 3, 5, 8);
    i_elems_0 = a; i_elems_1 = b; top_tuple = b; stall = 0; switch_output = 0;
    g = gsort(a, b);
    g2 = gsort(b, g[127:64]);
    repeat (6) @(posedge i_clk);
    #1;
    chk("chain_o0", c_elems_0, g2[63:0]);
    chk("chain_o1", c_elems_1, g2[127:64]);
    chk("chain_stall", 64'(c_st), 64'd0);
    chk("chain_sw", 64'(c_sw), 64'd0);
    $display("%0d/%0d checks passed", pass, total);
    $finish;
  end
endmodule
